// File: rtl/fetch_dispatch_fsm.sv
// Fetch/decode/dispatch controller: loads one instruction into IR, hands it to the ALU or external
// execute FSM, waits for completion under a timeout, then clears IR before the next fetch.
module fetch_dispatch_fsm #(
    parameter int IW      = 16,
    parameter int TIMEOUT = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [IW-1:0] mem_data,
    input  logic          mem_ready,
    input  logic          alu_done,
    input  logic          ex_done,
    output logic          PC_out,
    output logic          MAR_in,
    output logic          mem_rd,
    output logic          PC_inc,
    output logic [IW-1:0] IR,
    output logic          ex_start,
    output logic          busy,
    output logic          halted,
    output logic          err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_FETCH_ADDR = 3'd1;
    localparam logic [2:0] S_FETCH_WAIT = 3'd2;
    localparam logic [2:0] S_DECODE     = 3'd3;
    localparam logic [2:0] S_WAIT_ALU   = 3'd4;
    localparam logic [2:0] S_WAIT_EX    = 3'd5;
    localparam logic [2:0] S_CLEAR      = 3'd6;
    localparam logic [2:0] S_HALT       = 3'd7;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [IW-1:0] r_ir;
    logic          r_err;
    logic [3:0]    w_op;
    logic          w_in_wait;
    logic          w_event;
    logic          w_cnt_max;
    logic          w_timeout_fire;
    logic          w_cnt_clr;

    // Opcodes 1001-1111 belong to the ALU FSM.
    function automatic logic is_alu_op(input logic [3:0] op);
        return op[3] && (op[2:0] != 3'b000);
    endfunction

    // Opcodes 0001-0111 belong to the external execute FSM.
    function automatic logic is_ex_op(input logic [3:0] op);
        return !op[3] && (op[2:0] != 3'b000);
    endfunction

    assign w_op      = r_ir[IW-1 -: 4];
    assign w_cnt_max = (r_cnt == CW'(TIMEOUT - 1));

    // Identify the wait states and the completion event each one listens to.
    always_comb begin
        w_in_wait = 1'b0;
        w_event   = 1'b0;
        case (r_state)
            S_FETCH_WAIT: begin w_in_wait = 1'b1; w_event = mem_ready; end
            S_WAIT_ALU:   begin w_in_wait = 1'b1; w_event = alu_done;  end
            S_WAIT_EX:    begin w_in_wait = 1'b1; w_event = ex_done;   end
            default:      begin w_in_wait = 1'b0; w_event = 1'b0;      end
        endcase
    end

    // A completion event on the last allowed cycle wins over the timeout.
    assign w_timeout_fire = w_in_wait && w_cnt_max && !w_event;

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:       if (en) w_state_nxt = S_FETCH_ADDR; else w_state_nxt = S_IDLE;
            S_FETCH_ADDR: w_state_nxt = S_FETCH_WAIT;
            S_FETCH_WAIT: if (mem_ready)           w_state_nxt = S_DECODE;
                          else if (w_timeout_fire) w_state_nxt = S_CLEAR;
                          else                     w_state_nxt = S_FETCH_WAIT;
            S_DECODE:     if (is_alu_op(w_op))     w_state_nxt = S_WAIT_ALU;
                          else if (is_ex_op(w_op)) w_state_nxt = S_WAIT_EX;
                          else if (w_op[3])        w_state_nxt = S_HALT;
                          else                     w_state_nxt = S_CLEAR;
            S_WAIT_ALU:   if (alu_done || w_timeout_fire) w_state_nxt = S_CLEAR;
                          else                            w_state_nxt = S_WAIT_ALU;
            S_WAIT_EX:    if (ex_done || w_timeout_fire)  w_state_nxt = S_CLEAR;
                          else                            w_state_nxt = S_WAIT_EX;
            S_CLEAR:      if (en) w_state_nxt = S_FETCH_ADDR; else w_state_nxt = S_IDLE;
            S_HALT:       w_state_nxt = S_HALT;
            default:      w_state_nxt = S_IDLE;
        endcase
    end

    assign w_cnt_clr = (w_state_nxt != r_state) &&
                       ((w_state_nxt == S_FETCH_WAIT) || (w_state_nxt == S_WAIT_ALU) ||
                        (w_state_nxt == S_WAIT_EX));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Wait-state cycle counter, restarted on every wait-state entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_cnt <= {CW{1'b0}};
        else if (w_cnt_clr) r_cnt <= {CW{1'b0}};
        else if (w_in_wait) r_cnt <= r_cnt + CW'(1);
        else                r_cnt <= r_cnt;
    end

    // Instruction register: loaded on read data, zeroed in CLEAR, otherwise held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         r_ir <= {IW{1'b0}};
        else if ((r_state == S_FETCH_WAIT) && mem_ready)  r_ir <= mem_data;
        else if (r_state == S_CLEAR)                      r_ir <= {IW{1'b0}};
        else                                              r_ir <= r_ir;
    end

    // Sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                r_err <= 1'b0;
        else if (w_timeout_fire) r_err <= 1'b1;
        else                     r_err <= r_err;
    end

    assign PC_out   = (r_state == S_FETCH_ADDR);
    assign MAR_in   = (r_state == S_FETCH_ADDR);
    assign mem_rd   = (r_state == S_FETCH_WAIT);
    assign PC_inc   = (r_state == S_DECODE) && (w_op == 4'b0000);
    assign ex_start = (r_state == S_DECODE) && is_ex_op(w_op);
    assign busy     = (r_state != S_IDLE) && (r_state != S_HALT);
    assign halted   = (r_state == S_HALT);
    assign IR       = r_ir;
    assign err      = r_err;

endmodule

// File: tb/tb_fetch_dispatch_fsm.sv
// Scoreboard bench for fetch_dispatch_fsm: each issued instruction pushes its expected window summary,
// and a monitor summarises every FETCH_ADDR-delimited window the DUT produces and compares.
module tb_fetch_dispatch_fsm;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        alu_done = 1'b0;
    logic        ex_done = 1'b0;
    logic        PC_out, MAR_in, mem_rd, PC_inc, ex_start, busy, halted, err;
    logic [15:0] IR;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;
    bit abort = 1'b0;
    logic err_exp = 1'b0;

    typedef struct {
        logic [15:0] ir;
        int          len;
        int          nex;
        int          ninc;
        logic        err;
        logic        halted;
        logic        idle;
    } exp_t;
    exp_t sb[$];

    fetch_dispatch_fsm #(.IW(16), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .en(en), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_done(alu_done), .ex_done(ex_done), .PC_out(PC_out), .MAR_in(MAR_in),
        .mem_rd(mem_rd), .PC_inc(PC_inc), .IR(IR), .ex_start(ex_start), .busy(busy),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {23'd0, PC_out, MAR_in, mem_rd, PC_inc, ex_start, busy, halted, err};
    endfunction

    // Advance one cycle (sample point #1 after posedge) and drop all handshake inputs.
    task automatic step_clear();
        @(posedge clk); #1;
        mem_ready = 1'b0; alu_done = 1'b0; ex_done = 1'b0;
    endtask

    // Wait (bounded) for FETCH_ADDR, re-enabling the FSM if it parked in IDLE.
    task automatic wait_fetch(input string name);
        int n = 0;
        while (!PC_out && n < 40) begin
            if (!busy) en = 1'b1;
            step_clear();
            n++;
        end
        if (!PC_out) begin
            failures++; checks++;
            $display("FAIL %s no FETCH_ADDR within 40 cycles", name);
            abort = 1'b1;
        end
    endtask

    // Issue one instruction: w = FETCH_WAIT cycle carrying mem_ready (>32: never),
    // v = wait cycle carrying the matching done (>32: never), en_sel = en level during the instruction.
    task automatic issue(input logic [15:0] data, input int w, input int v, input logic en_sel);
        exp_t e;
        logic [3:0] op;
        bit is_alu;
        op = data[15:12];
        is_alu = (op > 4'h8);
        e.ir = data; e.nex = 0; e.ninc = 0; e.halted = 1'b0; e.idle = !en_sel; e.len = 1;
        if (w > 32) begin
            e.ir = 16'h0000; e.len += 33; err_exp = 1'b1;
        end else begin
            e.len += w + 1;
            if (op == 4'h0) begin
                e.ninc = 1; e.len += 1;
            end else if (op == 4'h8) begin
                e.halted = 1'b1; e.idle = 1'b1;
            end else begin
                if (!is_alu) e.nex = 1;
                if (v > 32) begin e.len += 33; err_exp = 1'b1; end
                else e.len += v + 1;
            end
        end
        e.err = err_exp;
        sb.push_back(e);

        wait_fetch("fetch_start");
        if (abort) return;
        en = en_sel;
        mem_ready = 1'($urandom); mem_data = 16'($urandom);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); #1;
            mem_ready = (k == w);
            mem_data  = (k == w) ? data : 16'($urandom);
            alu_done  = 1'($urandom); ex_done = 1'($urandom);
            if (k == w) break;
        end
        if (w > 32) return;
        @(posedge clk); #1;
        mem_ready = 1'($urandom); mem_data = 16'($urandom);
        alu_done = 1'($urandom); ex_done = 1'($urandom);
        if (op == 4'h0 || op == 4'h8) return;
        for (int j = 1; j <= 32; j++) begin
            @(posedge clk); #1;
            mem_ready = 1'($urandom);
            if (is_alu) begin alu_done = (j == v); ex_done = 1'($urandom); end
            else        begin ex_done = (j == v); alu_done = 1'($urandom); end
            if (j == v) break;
        end
    endtask

    // Monitor: summarise each window from FETCH_ADDR until the next FETCH_ADDR or a non-busy state.
    initial begin : monitor
        bit in_win = 1'b0;
        bit rd_seen, ir_set, zero_seen, stable;
        int len, nex, ninc;
        logic [15:0] ir_cap;
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (in_win && (PC_out || !busy)) begin
                    in_win = 1'b0;
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_underflow unexpected window len=%0d", len);
                    end else begin
                        e = sb.pop_front();
                        chk("win_ir", 32'(ir_cap), 32'(e.ir));
                        chk("win_len", 32'(len), 32'(e.len));
                        chk("win_ex_start", 32'(nex), 32'(e.nex));
                        chk("win_pc_inc", 32'(ninc), 32'(e.ninc));
                        chk("win_ir_stable", 32'(stable), 32'd1);
                        chk("win_err", 32'(err), 32'(e.err));
                        chk("win_halted", 32'(halted), 32'(e.halted));
                        chk("win_idle", 32'(!busy), 32'(e.idle));
                    end
                end
                if (!in_win && PC_out) begin
                    in_win = 1'b1; len = 0; nex = 0; ninc = 0;
                    rd_seen = 1'b0; ir_set = 1'b0; zero_seen = 1'b0; stable = 1'b1; ir_cap = 16'h0;
                end
                if (in_win) begin
                    len++; nex += 32'(ex_start); ninc += 32'(PC_inc);
                    if (ir_set) begin
                        if (IR == 16'h0000) zero_seen = 1'b1;
                        else if (zero_seen || IR != ir_cap) stable = 1'b0;
                    end else if (rd_seen && !mem_rd) begin
                        ir_set = 1'b1; ir_cap = IR;
                    end
                    if (mem_rd) rd_seen = 1'b1;
                end
            end
        end
    end

    initial begin : stimulus
        int w, v, cls;
        logic [15:0] d;
        #1;
        chk("reset_outputs", outs(), 32'd0);
        chk("reset_ir", 32'(IR), 32'd0);
        #11 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_after_reset", outs(), 32'd0);

        // Asynchronous reset taken mid-WAIT_ALU.
        en = 1'b1;
        wait_fetch("rst_fetch");
        if (!abort) begin
            @(posedge clk); #1; mem_ready = 1'b1; mem_data = 16'h9042;
            step_clear();
            step_clear();
            chk("wait_alu_ir", 32'(IR), 32'h9042);
            chk("wait_alu_busy", 32'(busy), 32'd1);
            #2 rst = 1'b0;
            #1 chk("async_rst_ir", 32'(IR), 32'd0);
            chk("async_rst_outputs", outs(), 32'd0);
            en = 1'b0;
            #3 rst = 1'b1;
            repeat (4) @(posedge clk);
            #1 chk("stay_idle_en0", outs(), 32'd0);
        end

        mon_en = 1'b1;
        if (!abort) issue(16'h0000, 1, 0, 1'b1);
        if (!abort) issue(16'hA083, 1, 9, 1'b1);
        if (!abort) issue(16'h3005, 2, 4, 1'b1);
        if (!abort) issue(16'hC0DE, 1, 33, 1'b1);
        if (!abort) issue(16'h0123, 33, 0, 1'b0);
        if (!abort) issue(16'h9FFF, 32, 32, 1'b1);
        if (!abort) issue(16'h7001, 3, 32, 1'b0);
        for (int i = 0; i < 30 && !abort; i++) begin
            cls = $urandom_range(0, 2);
            d = 16'($urandom);
            if (cls == 0)      d[15:12] = 4'h0;
            else if (cls == 1) d[15:12] = 4'($urandom_range(9, 15));
            else               d[15:12] = 4'($urandom_range(1, 7));
            w = ($urandom_range(0, 9) == 0) ? 33 : $urandom_range(1, 6);
            v = ($urandom_range(0, 9) == 0) ? 33 : $urandom_range(1, 12);
            issue(d, w, v, 1'($urandom_range(0, 3) != 0));
        end

        // HALT: parks with halted=1 regardless of en.
        if (!abort) begin
            issue(16'h8000, 2, 0, 1'b1);
            for (int i = 0; i < 12 && !abort; i++) begin
                step_clear();
                en = 1'($urandom);
                chk("halt_state", {29'd0, halted, busy, PC_out}, 32'b100);
            end
            chk("sb_drained", 32'(sb.size()), 32'd0);
            chk("err_sticky", 32'(err), 32'(err_exp));
        end
        #2 rst = 1'b0;
        #1 chk("final_rst_outputs", outs(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
